wb_cam_dma: RTL

//  Wishbone master (initiator) that drains 32-bit pixel words from the camera capture FIFO and

---
 rtl/cam_pkg.sv | 15 +
 rtl/cam_dma_watchdog.sv | 27 ++
 rtl/wb_cam_dma.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture DMA.
// State encoding, byte-select constant and default bus watchdog limit.
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    WRITE
  } state_t;

  localparam logic [127:0] WB_SEL_ALL = '1;
  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/cam_dma_watchdog.sv
// Bus watchdog: counts cycles while enabled, flags the TIMEOUT-th cycle.
// Cleared whenever the DMA leaves the WRITE state.
module cam_dma_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  assign expire = en && (cnt == W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/wb_cam_dma.sv
// Wishbone master draining the camera capture FIFO into frame memory.
// One classic single-beat write per pixel word, consecutive word addresses.
module wb_cam_dma
  import cam_pkg::*;
#(
  parameter int wb_dat_width = 32,
  parameter int wb_adr_width = 32,
  parameter int CNT_W        = 20,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [wb_adr_width-1:0]   base_adr,
  input  logic [CNT_W-1:0]          num_words,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [CNT_W-1:0]          words_done,
  input  logic                      fifo_empty,
  output logic                      fifo_rd,
  input  logic [wb_dat_width-1:0]   fifo_dout,
  output logic [wb_adr_width-1:0]   wbm_adr_o,
  output logic [wb_dat_width-1:0]   wbm_dat_o,
  output logic [wb_dat_width/8-1:0] wbm_sel_o,
  output logic                      wbm_we_o,
  output logic                      wbm_cyc_o,
  output logic                      wbm_stb_o,
  input  logic                      wbm_ack_i,
  input  logic                      wbm_err_i
);

  localparam int SW = wb_dat_width / 8;

  state_t state, state_d;

  logic [CNT_W-1:0]        count;
  logic [wb_adr_width-1:0] base_al;
  logic cyc_q;
  logic abort_l;
  logic abort_any;
  logic accept;
  logic zstart;
  logic load;
  logic ack_ok;
  logic fail;
  logic fin;
  logic wd_en;
  logic expire;

  assign base_al   = base_adr & ~wb_adr_width'(3);
  assign abort_any = abort | abort_l;

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = cyc_q;
  assign wbm_sel_o = cyc_q ? WB_SEL_ALL[SW-1:0] : '0;

  cam_dma_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk   (clk),
    .rst   (rst),
    .clr   (!wd_en),
    .en    (wd_en),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    fifo_rd = 1'b0;
    accept  = 1'b0;
    zstart  = 1'b0;
    load    = 1'b0;
    ack_ok  = 1'b0;
    fail    = 1'b0;
    fin     = 1'b0;
    wd_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            accept  = 1'b1;
            state_d = FETCH;
          end else begin
            zstart = 1'b1;
          end
        end
      end
      FETCH: begin
        if (abort_any) begin
          fin     = 1'b1;
          state_d = IDLE;
        end else if (!fifo_empty) begin
          fifo_rd = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load    = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        wd_en = 1'b1;
        // an error wins over a simultaneous ack
        if (wbm_err_i || (!wbm_ack_i && expire)) begin
          fail    = 1'b1;
          fin     = 1'b1;
          state_d = IDLE;
        end else if (wbm_ack_i) begin
          ack_ok = 1'b1;
          if (count == CNT_W'(1) || abort_any) begin
            fin     = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      words_done <= '0;
      count      <= '0;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
      cyc_q      <= 1'b0;
      abort_l    <= 1'b0;
    end else begin
      done <= fin | zstart;
      if (abort && state != IDLE) begin
        abort_l <= 1'b1;
      end
      if (accept) begin
        wbm_adr_o  <= base_al;
        count      <= num_words;
        words_done <= '0;
        err        <= 1'b0;
        busy       <= 1'b1;
        abort_l    <= 1'b0;
      end
      if (zstart) begin
        err <= 1'b0;
      end
      if (load) begin
        wbm_dat_o <= fifo_dout;
        cyc_q     <= 1'b1;
      end
      if (ack_ok) begin
        cyc_q      <= 1'b0;
        wbm_adr_o  <= wbm_adr_o + wb_adr_width'(4);
        words_done <= words_done + CNT_W'(1);
        count      <= count - CNT_W'(1);
      end
      if (fail) begin
        cyc_q <= 1'b0;
        err   <= 1'b1;
      end
      if (fin) begin
        busy    <= 1'b0;
        abort_l <= 1'b0;
      end
    end
  end

endmodule
